mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter that shares one single-ported unified memory between the instruction-fetch path and the load/store data path of the MIPS core. It accepts one request at a time from each side, arbitrates between them, drives a variable-latency req/ack memory port, and returns read data plus a one-cycle completion pulse to the granted requester. It sits between the core's fetch/LSU logic and the unified memory; the core stalls on each side until that side's done pulse.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched word, valid when if_done=1, held afterwards
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data, valid when d_done=1 after a load, held afterwards
- d_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid in the mem_ack cycle
- mem_ack  in  1  memory completion, single cycle, any latency ≥0 cycles after mem_req rises

## Operation
- States: IDLE, BUSY_IF, BUSY_D, DONE.
- IDLE: no request → stay. Only if_req → BUSY_IF. Only d_req → BUSY_D. Both → BUSY_D, unless streak == MAX_DATA_STREAK, then BUSY_IF.
- On entry to BUSY_*: mem_addr/mem_we/mem_wdata registered from the granted requester (fetch: mem_we=0, mem_wdata=0); mem_req=1 for the whole BUSY state.
- BUSY_*: mem_ack=0 → stay. mem_ack=1 → DONE; on that edge, if fetch: if_rdata←mem_rdata; if data load: d_rdata←mem_rdata; a store leaves d_rdata unchanged.
- DONE: mem_req=0; owner's done=1 for exactly this cycle; requests ignored; → IDLE.
- Streak counter (0..MAX_DATA_STREAK, saturating): on data grant with if_req=1 → +1; on data grant with if_req=0 → 0; on fetch grant → 0.
- mem_ack in IDLE or DONE is ignored.
- Request lines are not latched; a requester dropping req during BUSY has no effect — the transaction completes and done still pulses.
- Stores complete on mem_ack exactly like loads.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, streak=0. A transaction in flight is abandoned; the memory must tolerate mem_req dropping without ack.
- Request in IDLE at edge N → mem_req=1 from cycle N+1. mem_ack in cycle M → done=1 in cycle M+1 → IDLE in cycle M+2.
- Zero-wait memory (ack in the first BUSY cycle): 3 cycles per access from IDLE to IDLE; both done pulses are never high together.
- A requester wanting back-to-back accesses presents its next request in the DONE cycle or later; arbitration for it happens in the following IDLE cycle.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Single fetch, if_addr=0x0000_0040, ack 0 cycles after mem_req, mem_rdata=0x8C08_0004 → mem_req 1 cycle, mem_we=0, if_done pulse 1 cycle, if_rdata=0x8C08_0004; d_done stays 0.
- Store d_addr=0x100, d_wdata=0xDEAD_BEEF, ack after 3 cycles → mem_req high 4 cycles with mem_we=1, mem_wdata=0xDEAD_BEEF; d_done pulse; d_rdata unchanged.
- if_req and d_req both held continuously, MAX_DATA_STREAK=4, zero-wait memory → grant order D,D,D,D,IF,D,D,D,D,IF…
- Fetch alone for 3 transactions then d_req joins → next grant is data; streak starts at 1.
- Assert rst mid-BUSY_D (before ack), then release with no requests → all outputs 0 immediately on reset; no done pulse; IDLE afterwards; late mem_ack ignored.
- Spurious mem_ack in IDLE with mem_rdata=0x1234 → no done pulse; if_rdata/d_rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between the fetch path
// and the load/store path. One request at a time is granted, run on a
// variable-latency req/ack memory port, and completed with a one-cycle done
// pulse to its owner. Data has priority, capped by a streak limit so that a
// waiting fetch is never starved.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   if_req/if_addr                fetch request, held until if_done
//   if_rdata/if_done              fetched word (held) and completion pulse
//   d_req/d_we/d_addr/d_wdata     data request, held until d_done
//   d_rdata/d_done                load data (held) and completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     memory request, held until mem_ack
//   mem_rdata/mem_ack             memory read data and single-cycle completion
// All outputs are registered.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q,     state_d;
  logic [STREAK_W-1:0]   streak_q,    streak_d;
  logic                  mem_req_q,   mem_req_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
  logic                  if_done_q,   if_done_d;
  logic                  d_done_q,    d_done_d;
  logic                  streak_full;

  assign streak_full = (streak_q == STREAK_W'(MAX_DATA_STREAK));

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  // Arbitration, memory handshake and completion
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && !(if_req && streak_full)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Data only wins against a waiting fetch below the cap, so the
          // increment cannot pass MAX_DATA_STREAK.
          if (if_req) begin
            streak_d = streak_q + STREAK_W'(1);
          end else begin
            streak_d = '0;
          end
        end else if (if_req) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_done_d  = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          // A store leaves the last load value in place.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of arbitration and memory.
module tb_mem_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_DATA_STREAK (MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // One cycle against a zero-wait memory; reports the done pulses seen.
  task automatic zw_step(output bit gi, output bit gd);
    @(negedge clk);
    gi        = if_done;
    gd        = d_done;
    mem_ack   = mem_req;
    mem_rdata = $urandom;
  endtask

  // Drop all requests and let any in-flight access finish.
  task automatic drain();
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (6) begin
      @(negedge clk);
      mem_ack = mem_req;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_done, d_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {mem_req, mem_we, if_done, d_done});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin
      errors++;
      $display("FAIL reset_buses: got %h %h %h %h expected all 0", mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, if_done, d_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 000", {mem_req, if_done, d_done});
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_done} !== 3'b100 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL fetch_busy: got req/we/done=%b addr=%h expected 100 addr=00000040",
               {mem_req, mem_we, if_done}, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h8C08_0004;
    @(negedge clk);
    mem_ack = 1'b0;
    if_req  = 1'b0;
    checks++;
    if ({mem_req, if_done, d_done} !== 3'b010) begin
      errors++;
      $display("FAIL fetch_done: got req/if_done/d_done=%b expected 010", {mem_req, if_done, d_done});
    end
    checks++;
    if (if_rdata !== 32'h8C08_0004) begin
      errors++;
      $display("FAIL fetch_rdata: got %h expected 8c080004", if_rdata);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, if_done, d_done} !== 3'b000 || if_rdata !== 32'h8C08_0004) begin
      errors++;
      $display("FAIL fetch_after: got %b rdata=%h expected 000 rdata=8c080004",
               {mem_req, if_done, d_done}, if_rdata);
    end
  endtask

  task automatic test_store();
    logic [31:0] old_d;
    old_d = d_rdata;
    @(negedge clk);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, d_done} !== 3'b110 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h100) begin
        errors++;
        $display("FAIL store_busy%0d: got req/we/done=%b addr=%h wdata=%h expected 110 00000100 deadbeef",
                 k, {mem_req, mem_we, d_done}, mem_addr, mem_wdata);
      end
      mem_ack = (k == 3);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    d_req   = 1'b0;
    checks++;
    if ({mem_req, d_done, if_done} !== 3'b010 || d_rdata !== old_d) begin
      errors++;
      $display("FAIL store_done: got req/d_done/if_done=%b d_rdata=%h expected 010 d_rdata=%h",
               {mem_req, d_done, if_done}, d_rdata, old_d);
    end
    @(negedge clk);
    checks++;
    if (d_done !== 1'b0) begin
      errors++;
      $display("FAIL store_pulse_len: got d_done=%b expected 0", d_done);
    end
  endtask

  task automatic test_spurious_ack();
    logic [31:0] old_if, old_d;
    old_if = if_rdata;
    old_d  = d_rdata;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, if_done, d_done} !== 3'b000 || if_rdata !== old_if || d_rdata !== old_d) begin
        errors++;
        $display("FAIL spurious_ack%0d: got %b if_rdata=%h d_rdata=%h expected 000 %h %h",
                 k, {mem_req, if_done, d_done}, if_rdata, d_rdata, old_if, old_d);
      end
    end
  endtask

  task automatic test_streak();
    bit gi, gd;
    int order[$];
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h100;
    for (int k = 0; k < 45 && order.size() < 10; k++) begin
      zw_step(gi, gd);
      checks++;
      if (gi && gd) begin
        errors++;
        $display("FAIL streak_both_done: got if_done=1 d_done=1 expected at most one");
      end
      if (gd) order.push_back(0);
      else if (gi) order.push_back(1);
    end
    checks++;
    if (order.size() != 10) begin
      errors++;
      $display("FAIL streak_count: got %0d grants expected 10", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] != ((k % 5 == 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL streak_order%0d: got %s expected %s", k,
                 order[k] ? "IF" : "D", (k % 5 == 4) ? "IF" : "D");
      end
    end
    drain();
  endtask

  task automatic test_fetch_then_data();
    bit gi, gd;
    int nif = 0;
    int nd  = 0;
    int order[$];
    if_req  = 1'b1;
    if_addr = 32'h44;
    d_req   = 1'b0;
    for (int k = 0; k < 30 && nif < 3; k++) begin
      zw_step(gi, gd);
      if (gi) nif++;
      if (gd) nd++;
    end
    checks++;
    if (nif != 3 || nd != 0) begin
      errors++;
      $display("FAIL ftd_fetch_phase: got %0d fetches %0d data expected 3 and 0", nif, nd);
    end
    // Joins during the DONE cycle of the third fetch.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h108;
    d_wdata = $urandom;
    for (int k = 0; k < 30 && order.size() < 5; k++) begin
      zw_step(gi, gd);
      if (gd) order.push_back(0);
      else if (gi) order.push_back(1);
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL ftd_count: got %0d grants expected 5", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] != ((k == 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL ftd_order%0d: got %s expected %s", k,
                 order[k] ? "IF" : "D", (k == 4) ? "IF" : "D");
      end
    end
    drain();
  endtask

  // Random requesters and memory latency against a transaction-level model.
  task automatic test_random(input int ncyc, input int p_if, input int p_d, input int max_lat);
    logic [31:0] mem_m [16];
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    logic [31:0] t_addr  = '0;
    logic [31:0] t_wdata = '0;
    logic [3:0]  idx;
    bit t_we     = 1'b0;
    bit own_if   = 1'b0;
    bit in_txn   = 1'b0;
    bit if_out   = 1'b0;
    bit d_out    = 1'b0;
    bit exp_ifd, exp_dd;
    int streak_m = 0;
    int lat      = 0;
    int done_cyc = -1;
    int free_cyc = 0;

    rst     = 1'b0;
    if_req  = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    @(negedge clk);
    rst = 1'b1;

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_ifd = (c == done_cyc) && own_if;
      exp_dd  = (c == done_cyc) && !own_if;
      checks++;
      if (mem_req !== in_txn) begin
        errors++;
        $display("FAIL rnd_mem_req c=%0d: got %b expected %b", c, mem_req, in_txn);
      end
      if (in_txn) begin
        checks++;
        if (mem_addr !== t_addr || mem_we !== t_we || mem_wdata !== t_wdata) begin
          errors++;
          $display("FAIL rnd_mem_cmd c=%0d: got addr=%h we=%b wdata=%h expected %h %b %h",
                   c, mem_addr, mem_we, mem_wdata, t_addr, t_we, t_wdata);
        end
      end
      checks++;
      if (if_done !== exp_ifd || d_done !== exp_dd) begin
        errors++;
        $display("FAIL rnd_done c=%0d: got if_done=%b d_done=%b expected %b %b",
                 c, if_done, d_done, exp_ifd, exp_dd);
      end
      checks++;
      if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
        errors++;
        $display("FAIL rnd_rdata c=%0d: got if=%h d=%h expected %h %h",
                 c, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
      end

      // Requesters retire on their done and may re-request straight away.
      if (c == done_cyc) begin
        if (own_if) if_out = 1'b0;
        else        d_out  = 1'b0;
      end
      if (!if_out && $urandom_range(99) < p_if) begin
        if_out  = 1'b1;
        if_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
      end
      if (!d_out && $urandom_range(99) < p_d) begin
        d_out   = 1'b1;
        d_we    = 1'($urandom_range(1));
        d_addr  = {22'd0, 4'b0100, 4'($urandom_range(15)), 2'b00};
        d_wdata = $urandom;
      end
      if_req = if_out;
      d_req  = d_out;

      // Memory side; stray acks outside an access must be ignored.
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (in_txn) begin
        if (lat == 0) begin
          mem_ack = 1'b1;
          idx     = t_addr[5:2];
          if (t_we) begin
            mem_m[idx] = t_wdata;
          end else begin
            mem_rdata = mem_m[idx];
            if (own_if) exp_if_rdata = mem_rdata;
            else        exp_d_rdata  = mem_rdata;
          end
          in_txn   = 1'b0;
          done_cyc = c + 1;
          free_cyc = c + 2;
        end else begin
          lat--;
        end
      end else if ($urandom_range(9) == 0) begin
        mem_ack = 1'b1;
      end

      // Grant decided from the requests present in an idle cycle.
      if (!in_txn && c >= free_cyc && (if_out || d_out)) begin
        own_if = if_out && (!d_out || streak_m == MAX);
        if (own_if)      streak_m = 0;
        else if (if_out) streak_m = (streak_m + 1 > MAX) ? MAX : streak_m + 1;
        else             streak_m = 0;
        t_addr  = own_if ? if_addr : d_addr;
        t_we    = own_if ? 1'b0 : d_we;
        t_wdata = own_if ? 32'd0 : d_wdata;
        in_txn  = 1'b1;
        lat     = $urandom_range(max_lat);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h104;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rmb_busy: got mem_req=%b expected 1", mem_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, if_done, d_done} !== 4'b0000 ||
        {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin
      errors++;
      $display("FAIL rmb_async: got %b %h %h %h %h expected all 0",
               {mem_req, mem_we, if_done, d_done}, mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_CAFE;
    checks++;
    if ({mem_req, if_done, d_done} !== 3'b000) begin
      errors++;
      $display("FAIL rmb_idle: got %b expected 000", {mem_req, if_done, d_done});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, if_done, d_done} !== 3'b000 || d_rdata !== 32'd0) begin
        errors++;
        $display("FAIL rmb_late_ack%0d: got %b d_rdata=%h expected 000 0",
                 k, {mem_req, if_done, d_done}, d_rdata);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_single_fetch();
    test_store();
    test_spurious_ack();
    test_streak();
    test_fetch_then_data();
    test_random(600, 60, 60, 3);
    test_random(400, 95, 95, 0);
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
